// File: rtl/xif_copro_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : xif_copro_result_stage
// Description : Merges execution and memory results into one ordered XIF
//               result stream, with a small FIFO and an empty-FIFO bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module xif_copro_result_stage #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFW_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ex_valid_i,
  output logic                   ex_ready_o,
  input  logic [X_ID_WIDTH-1:0]  ex_id_i,
  input  logic [X_RFW_WIDTH-1:0] ex_data_i,
  input  logic [4:0]             ex_rd_i,
  input  logic                   ex_we_i,
  input  logic                   mem_valid_i,
  input  logic [X_ID_WIDTH-1:0]  mem_id_i,
  input  logic [X_RFW_WIDTH-1:0] mem_data_i,
  input  logic [4:0]             mem_rd_i,
  input  logic                   mem_we_i,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic [X_ID_WIDTH-1:0]  result_id_o,
  output logic [X_RFW_WIDTH-1:0] result_data_o,
  output logic [4:0]             result_rd_o,
  output logic                   result_we_o,
  output logic                   result_pending_o,
  output logic                   overflow_o
);

  localparam int c_PTR_W   = $clog2(DEPTH);
  localparam int c_CNT_W   = $clog2(DEPTH + 1);
  localparam int c_ENTRY_W = X_ID_WIDTH + X_RFW_WIDTH + 6;

  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_RESERVE = c_CNT_W'(DEPTH - 1);

  logic [c_ENTRY_W-1:0] r_fifo [DEPTH];
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_overflow;

  logic                 w_nonempty;
  logic                 w_in_v;
  logic                 w_pop;
  logic                 w_bypass;
  logic                 w_drop;
  logic                 w_push;
  logic [c_ENTRY_W-1:0] w_in_entry;
  logic [c_ENTRY_W-1:0] w_out_entry;

  assign w_nonempty = (r_count != '0);

  // One slot always stays free for a memory result, which cannot be stalled.
  assign ex_ready_o = ~mem_valid_i & (r_count < c_RESERVE);
  assign w_in_v     = mem_valid_i | (ex_valid_i & ex_ready_o);
  assign w_in_entry = mem_valid_i ? {mem_id_i, mem_data_i, mem_rd_i, mem_we_i}
                                  : {ex_id_i,  ex_data_i,  ex_rd_i,  ex_we_i};

  assign w_pop    = w_nonempty & result_ready_i;
  assign w_bypass = ~w_nonempty & result_ready_i;
  assign w_drop   = mem_valid_i & (r_count == c_FULL) & ~w_pop;
  assign w_push   = w_in_v & ~w_bypass & ~w_drop;

  assign w_out_entry = w_nonempty ? r_fifo[r_rd_ptr] : w_in_entry;

  assign result_valid_o   = w_nonempty | w_in_v;
  assign result_id_o      = w_out_entry[c_ENTRY_W-1 -: X_ID_WIDTH];
  assign result_data_o    = w_out_entry[X_RFW_WIDTH+5 -: X_RFW_WIDTH];
  assign result_rd_o      = w_out_entry[5:1];
  assign result_we_o      = w_out_entry[0];
  assign result_pending_o = w_nonempty;
  assign overflow_o       = r_overflow;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + c_CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - c_CNT_W'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (w_push && !rst_i) r_fifo[r_wr_ptr] <= w_in_entry;
  end

endmodule
`default_nettype wire

// File: tb/tb_xif_copro_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_xif_copro_result_stage
// Description : Directed self-checking bench for xif_copro_result_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xif_copro_result_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [3:0]  ex_id_i;
  logic [31:0] ex_data_i;
  logic [4:0]  ex_rd_i;
  logic        ex_we_i;
  logic        mem_valid_i;
  logic [3:0]  mem_id_i;
  logic [31:0] mem_data_i;
  logic [4:0]  mem_rd_i;
  logic        mem_we_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [3:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;
  logic        result_pending_o;
  logic        overflow_o;

  int n_checks = 0;
  int n_errors = 0;

  xif_copro_result_stage #(
    .X_ID_WIDTH(4), .X_RFW_WIDTH(32), .DEPTH(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_id_i(ex_id_i),
    .ex_data_i(ex_data_i), .ex_rd_i(ex_rd_i), .ex_we_i(ex_we_i),
    .mem_valid_i(mem_valid_i), .mem_id_i(mem_id_i), .mem_data_i(mem_data_i),
    .mem_rd_i(mem_rd_i), .mem_we_i(mem_we_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_rd_o(result_rd_o), .result_we_o(result_we_o),
    .result_pending_o(result_pending_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ex_valid_i  = 1'b0; ex_id_i  = '0; ex_data_i  = '0; ex_rd_i  = '0; ex_we_i  = 1'b0;
    mem_valid_i = 1'b0; mem_id_i = '0; mem_data_i = '0; mem_rd_i = '0; mem_we_i = 1'b0;
  endtask

  task automatic put_ex(input logic [3:0] id, input logic [31:0] d);
    ex_valid_i = 1'b1; ex_id_i = id; ex_data_i = d; ex_rd_i = {1'b0, id}; ex_we_i = 1'b1;
  endtask

  task automatic put_mem(input logic [3:0] id, input logic [31:0] d);
    mem_valid_i = 1'b1; mem_id_i = id; mem_data_i = d; mem_rd_i = 5'd20; mem_we_i = 1'b0;
  endtask

  // Advance one clock and return to the negedge, then let inputs settle.
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic fill_ex3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    result_ready_i = 1'b0;
    put_ex(a, {28'h0, a}); step();
    put_ex(b, {28'h0, b}); step();
    put_ex(c, {28'h0, c}); step();
    idle(); #1;
  endtask

  initial begin
    result_ready_i = 1'b0;
    @(negedge clk_i);
    do_reset();
    check_eq("rst_valid",   result_valid_o,   0);
    check_eq("rst_pending", result_pending_o, 0);
    check_eq("rst_ovf",     overflow_o,       0);
    check_eq("rst_exrdy",   ex_ready_o,       1);

    // Bypass
    result_ready_i = 1'b1;
    put_ex(4'd3, 32'hDEADBEEF); #1;
    check_eq("byp_valid",   result_valid_o,   1);
    check_eq("byp_id",      result_id_o,      3);
    check_eq("byp_data",    result_data_o,    32'hDEADBEEF);
    check_eq("byp_rd",      result_rd_o,      3);
    check_eq("byp_we",      result_we_o,      1);
    check_eq("byp_exrdy",   ex_ready_o,       1);
    check_eq("byp_pending", result_pending_o, 0);
    step(); idle(); #1;
    check_eq("byp_after_pending", result_pending_o, 0);
    check_eq("byp_after_valid",   result_valid_o,   0);

    // Back-pressure
    result_ready_i = 1'b0;
    put_ex(4'd1, 32'h11); #1;
    check_eq("bp_exrdy0", ex_ready_o,  1);
    check_eq("bp_out0",   result_id_o, 1);
    step();
    put_ex(4'd2, 32'h22); #1;
    check_eq("bp_exrdy1", ex_ready_o,  1);
    check_eq("bp_head1",  result_id_o, 1);
    step();
    put_ex(4'd3, 32'h33); #1;
    check_eq("bp_exrdy2", ex_ready_o,  1);
    step();
    put_ex(4'd9, 32'h99); #1;
    check_eq("bp_exrdy3", ex_ready_o,       0);
    check_eq("bp_pend3",  result_pending_o, 1);
    check_eq("bp_stable", result_id_o,      1);
    idle(); result_ready_i = 1'b1; #1;
    check_eq("bp_drain1", result_id_o,   1);
    check_eq("bp_data1",  result_data_o, 32'h11);
    step();
    check_eq("bp_drain2", result_id_o, 2);
    step();
    check_eq("bp_drain3", result_id_o,      3);
    check_eq("bp_pend_last", result_pending_o, 1);
    step();
    check_eq("bp_pend_end",  result_pending_o, 0);
    check_eq("bp_valid_end", result_valid_o,   0);

    // Priority
    put_mem(4'd7, 32'h77); put_ex(4'd8, 32'h88); #1;
    check_eq("pri_id",    result_id_o,    7);
    check_eq("pri_data",  result_data_o,  32'h77);
    check_eq("pri_we",    result_we_o,    0);
    check_eq("pri_exrdy", ex_ready_o,     0);
    step();
    mem_valid_i = 1'b0; #1;
    check_eq("pri_next_id",   result_id_o,      8);
    check_eq("pri_next_rdy",  ex_ready_o,       1);
    check_eq("pri_next_pend", result_pending_o, 0);
    step(); idle(); #1;

    // Simultaneous push/pop at count 2
    result_ready_i = 1'b0;
    put_ex(4'd10, 32'hA0); step();
    put_ex(4'd11, 32'hB0); step();
    idle();
    result_ready_i = 1'b1;
    put_mem(4'd12, 32'hC0); #1;
    check_eq("pp_head", result_id_o, 10);
    step();
    idle(); result_ready_i = 1'b0; #1;
    check_eq("pp_exrdy_cnt2", ex_ready_o,  1);
    check_eq("pp_next",       result_id_o, 11);
    result_ready_i = 1'b1; #1;
    step();
    check_eq("pp_pushed", result_id_o,   12);
    check_eq("pp_pdata",  result_data_o, 32'hC0);
    step();
    check_eq("pp_empty", result_pending_o, 0);

    // Overflow
    fill_ex3(4'd1, 4'd2, 4'd3);
    put_mem(4'd4, 32'h44); #1;
    check_eq("ovf_before", overflow_o, 0);
    step();
    put_mem(4'd5, 32'h55); #1;
    check_eq("ovf_not_yet", overflow_o, 0);
    step();
    idle(); #1;
    check_eq("ovf_set",   overflow_o, 1);
    check_eq("ovf_exrdy", ex_ready_o, 0);
    result_ready_i = 1'b1; #1;
    for (int i = 1; i <= 4; i++) begin
      check_eq($sformatf("ovf_drain%0d", i), result_id_o, i);
      step();
    end
    check_eq("ovf_dropped", result_valid_o, 0);
    check_eq("ovf_sticky",  overflow_o,     1);

    // Reset mid-operation
    fill_ex3(4'd6, 4'd7, 4'd8);
    check_eq("mid_pend", result_pending_o, 1);
    do_reset();
    check_eq("mid_valid", result_valid_o,   0);
    check_eq("mid_pend0", result_pending_o, 0);
    check_eq("mid_ovf",   overflow_o,       0);
    check_eq("mid_exrdy", ex_ready_o,       1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
